// File: rtl/csr_pkg.sv
// Shared types, CSR address map and helpers for the performance/timer counter block.
package csr_pkg;

    typedef logic [11:0] csr_addr_t;

    typedef enum logic [1:0] {
        PrivU = 2'b00,
        PrivS = 2'b01,
        PrivM = 2'b11
    } priv_mode_t;

    typedef enum logic [1:0] {
        CsrNone = 2'b00,
        CsrRw   = 2'b01,
        CsrRs   = 2'b10,
        CsrRc   = 2'b11
    } csr_write_func;

    localparam csr_addr_t CsrMcycle        = 12'hB00;
    localparam csr_addr_t CsrMinstret      = 12'hB02;
    localparam csr_addr_t CsrMcycleh       = 12'hB80;
    localparam csr_addr_t CsrMinstreth     = 12'hB82;
    localparam csr_addr_t CsrCycle         = 12'hC00;
    localparam csr_addr_t CsrTime          = 12'hC01;
    localparam csr_addr_t CsrInstret       = 12'hC02;
    localparam csr_addr_t CsrCycleh        = 12'hC80;
    localparam csr_addr_t CsrMcountinhibit = 12'h320;
    localparam csr_addr_t CsrMcounteren    = 12'h306;

    localparam logic [3:0] CsrMachCntPage = 4'hB;
    localparam logic [3:0] CsrUserCntPage = 4'hC;

    // Bit 0 (cycle) and bits 2..2+num_hpm are implemented; bit 1 (time) never is.
    function automatic logic [31:0] cnt_wr_mask(int unsigned num_hpm);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            m[i] = (i == 0) || ((i >= 2) && (i <= 2 + num_hpm));
        end
        return m;
    endfunction

    function automatic logic [31:0] csr_apply(csr_write_func func, logic [31:0] old_val,
                                              logic [31:0] wdata);
        logic [31:0] res;
        unique case (func)
            CsrRw:   res = wdata;
            CsrRs:   res = old_val | wdata;
            CsrRc:   res = old_val & ~wdata;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// Single wrapping counter with add-by-N increment and 32-bit half-word write ports.
module csr_counter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned INC_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [INC_W-1:0] inc_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // A write owns the counter for that cycle: the increment is dropped.
    always_comb begin
        cnt_d = cnt_q + WIDTH'(inc_i);
        if (wr_lo_i) begin
            cnt_d = {cnt_q[WIDTH-1:32], wdata_i};
        end else if (wr_hi_i) begin
            cnt_d = {wdata_i[WIDTH-33:0], cnt_q[31:0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_counters.sv
// Machine/user counter CSRs: mcycle, time, minstret, mhpmcounters plus inhibit/enable regs.
module csr_counters
    import csr_pkg::*;
#(
    parameter int unsigned NUM_HPM       = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned RETIRE_MAX    = 1,
    localparam int unsigned RetW         = $clog2(RETIRE_MAX + 1),
    localparam int unsigned HpmW         = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  priv_mode_t      priv_mode,
    input  logic            csr_valid,
    input  csr_addr_t       csr_addr,
    input  csr_write_func   csr_func,
    input  logic [31:0]     csr_wdata,
    output logic [31:0]     csr_rdata,
    output logic            csr_illegal,
    input  logic [RetW-1:0] retire_count,
    input  logic [HpmW-1:0] hpm_event,
    input  logic            time_tick
);

    localparam logic [31:0] WrMask = cnt_wr_mask(NUM_HPM);

    logic [31:0] inhibit_q, inhibit_d;
    logic [31:0] counteren_q, counteren_d;

    logic [COUNTER_WIDTH-1:0] cycle_val, time_val, instret_val;
    logic [COUNTER_WIDTH-1:0] hpm_val [HpmW];
    logic [63:0]              cnt_view [32];

    logic [4:0]  idx;
    logic        hi, in_win, is_b, is_c, is_inh, is_en, is_m, is_write;
    logic        illegal, we, cnt_we;
    logic [31:0] old_val, new_val;

    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            cnt_view[i] = '0;
        end
        cnt_view[0] = 64'(cycle_val);
        cnt_view[1] = 64'(time_val);
        cnt_view[2] = 64'(instret_val);
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            cnt_view[3+i] = 64'(hpm_val[i]);
        end
    end

    always_comb begin
        idx      = csr_addr[4:0];
        hi       = csr_addr[7];
        in_win   = (csr_addr[6:5] == 2'b00);
        // 0xB01/0xB81 would alias time, which has no machine-writable address.
        is_b     = (csr_addr[11:8] == CsrMachCntPage) && in_win && (idx != 5'd1);
        is_c     = (csr_addr[11:8] == CsrUserCntPage) && in_win;
        is_inh   = (csr_addr == CsrMcountinhibit);
        is_en    = (csr_addr == CsrMcounteren);
        is_m     = (priv_mode == PrivM);
        is_write = (csr_func != CsrNone);

        illegal = 1'b0;
        if (reset_n && csr_valid) begin
            if (!(is_b || is_c || is_inh || is_en)) begin
                illegal = 1'b1;
            end else if (!is_m && !is_c) begin
                illegal = 1'b1;
            end else if (is_c && is_write) begin
                illegal = 1'b1;
            end else if (is_c && !is_m && !counteren_q[idx]) begin
                illegal = 1'b1;
            end
        end

        if (is_inh) begin
            old_val = inhibit_q;
        end else if (is_en) begin
            old_val = counteren_q;
        end else begin
            old_val = hi ? cnt_view[idx][63:32] : cnt_view[idx][31:0];
        end

        new_val   = csr_apply(csr_func, old_val, csr_wdata);
        we        = reset_n && csr_valid && !illegal && is_write;
        cnt_we    = we && is_b;
        csr_rdata = (reset_n && csr_valid && !illegal) ? old_val : 32'h0;

        inhibit_d   = (we && is_inh) ? (new_val & WrMask) : inhibit_q;
        counteren_d = (we && is_en)  ? (new_val & WrMask) : counteren_q;
    end

    assign csr_illegal = illegal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inhibit_q   <= '0;
            counteren_q <= '0;
        end else begin
            inhibit_q   <= inhibit_d;
            counteren_q <= counteren_d;
        end
    end

    csr_counter #(
        .WIDTH (COUNTER_WIDTH),
        .INC_W (1)
    ) u_mcycle (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .inc_i   (~inhibit_q[0]),
        .wr_lo_i (cnt_we && !hi && (idx == 5'd0)),
        .wr_hi_i (cnt_we && hi && (idx == 5'd0)),
        .wdata_i (new_val),
        .value_o (cycle_val)
    );

    csr_counter #(
        .WIDTH (COUNTER_WIDTH),
        .INC_W (1)
    ) u_time (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .inc_i   (time_tick),
        .wr_lo_i (1'b0),
        .wr_hi_i (1'b0),
        .wdata_i (new_val),
        .value_o (time_val)
    );

    csr_counter #(
        .WIDTH (COUNTER_WIDTH),
        .INC_W (RetW)
    ) u_minstret (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .inc_i   ({RetW{~inhibit_q[2]}} & retire_count),
        .wr_lo_i (cnt_we && !hi && (idx == 5'd2)),
        .wr_hi_i (cnt_we && hi && (idx == 5'd2)),
        .wdata_i (new_val),
        .value_o (instret_val)
    );

    for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
        csr_counter #(
            .WIDTH (COUNTER_WIDTH),
            .INC_W (1)
        ) u_hpm (
            .clk_i   (clock),
            .rst_ni  (reset_n),
            .inc_i   (hpm_event[i] & ~inhibit_q[3+i]),
            .wr_lo_i (cnt_we && !hi && (idx == 5'(3 + i))),
            .wr_hi_i (cnt_we && hi && (idx == 5'(3 + i))),
            .wdata_i (new_val),
            .value_o (hpm_val[i])
        );
    end

    if (NUM_HPM == 0) begin : g_no_hpm
        assign hpm_val[0] = '0;
    end

endmodule

// File: tb/tb_csr_counters.sv
// Self-checking bench for csr_counters: directed vectors, corner sequences, random vs model.
module tb_csr_counters;
    import csr_pkg::*;

    localparam int unsigned NumHpm = 4;
    localparam logic [31:0] MMask  = 32'h0000_007D;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    priv_mode_t    priv_mode = PrivM;
    logic          csr_valid = 1'b0;
    csr_addr_t     csr_addr = '0;
    csr_write_func csr_func = CsrNone;
    logic [31:0]   csr_wdata = '0;
    logic [31:0]   csr_rdata;
    logic          csr_illegal;
    logic [0:0]    retire_count = '0;
    logic [3:0]    hpm_event = '0;
    logic          time_tick = 1'b0;

    always #5 clock = ~clock;

    csr_counters #(
        .NUM_HPM       (NumHpm),
        .COUNTER_WIDTH (64),
        .RETIRE_MAX    (1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .priv_mode    (priv_mode),
        .csr_valid    (csr_valid),
        .csr_addr     (csr_addr),
        .csr_func     (csr_func),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .retire_count (retire_count),
        .hpm_event    (hpm_event),
        .time_tick    (time_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    longint unsigned m_cnt [32];
    logic [31:0]     m_inh;
    logic [31:0]     m_en;

    typedef struct {
        bit            v;
        priv_mode_t    p;
        logic [11:0]   a;
        csr_write_func f;
        logic [31:0]   w;
        bit            ill;
        logic [31:0]   rd;
    } vec_t;

    vec_t vecs [22];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_inh = '0;
        m_en  = '0;
    endtask

    function automatic bit in_range(logic [11:0] a, logic [11:0] lo, logic [11:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic bit m_illegal(bit v, logic [11:0] a, csr_write_func f, priv_mode_t p);
        bit m;
        int unsigned idx;
        m   = (p == PrivM);
        idx = a[4:0];
        if (!v) return 1'b0;
        if (a == 12'h320 || a == 12'h306) return !m;
        if (in_range(a, 12'hB00, 12'hB1F) || in_range(a, 12'hB80, 12'hB9F))
            return (idx == 1) || !m;
        if (in_range(a, 12'hC00, 12'hC1F) || in_range(a, 12'hC80, 12'hC9F))
            return (f != CsrNone) || (!m && !m_en[idx]);
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read_raw(logic [11:0] a);
        longint unsigned v;
        if (a == 12'h320) return m_inh;
        if (a == 12'h306) return m_en;
        v = m_cnt[a[4:0]];
        return a[7] ? v[63:32] : v[31:0];
    endfunction

    task automatic model_step();
        bit              ill, we, hi;
        logic [31:0]     oldv, newv;
        int unsigned     idx;
        longint unsigned inc;
        ill  = m_illegal(csr_valid, csr_addr, csr_func, priv_mode);
        we   = csr_valid && !ill && (csr_func != CsrNone);
        oldv = m_read_raw(csr_addr);
        case (csr_func)
            CsrRw:   newv = csr_wdata;
            CsrRs:   newv = oldv | csr_wdata;
            CsrRc:   newv = oldv & ~csr_wdata;
            default: newv = oldv;
        endcase
        idx = csr_addr[4:0];
        hi  = csr_addr[7];
        for (int unsigned k = 0; k < 32; k++) begin
            if (k == 0)               inc = m_inh[0] ? 0 : 1;
            else if (k == 1)          inc = time_tick;
            else if (k == 2)          inc = m_inh[2] ? 0 : retire_count;
            else if (k < 3 + NumHpm)  inc = m_inh[k] ? 0 : hpm_event[k-3];
            else                      inc = 0;
            if (we && csr_addr[11:8] == 4'hB && idx == k && k < 3 + NumHpm) begin
                if (hi) m_cnt[k] = {newv, m_cnt[k][31:0]};
                else    m_cnt[k] = {m_cnt[k][63:32], newv};
            end else begin
                m_cnt[k] = m_cnt[k] + inc;
            end
        end
        if (we && csr_addr == 12'h320) m_inh = newv & MMask;
        if (we && csr_addr == 12'h306) m_en  = newv & MMask;
    endtask

    task automatic set_in(bit v, logic [11:0] a, csr_write_func f, logic [31:0] w,
                          priv_mode_t p, bit r, logic [3:0] h, bit t);
        csr_valid    = v;
        csr_addr     = a;
        csr_func     = f;
        csr_wdata    = w;
        priv_mode    = p;
        retire_count = r;
        hpm_event    = h;
        time_tick    = t;
    endtask

    task automatic settle();
        bit          ill;
        logic [31:0] rd;
        #1;
        ill = m_illegal(csr_valid, csr_addr, csr_func, priv_mode);
        rd  = (csr_valid && !ill) ? m_read_raw(csr_addr) : 32'h0;
        check("model_illegal", {31'b0, csr_illegal}, {31'b0, ill});
        check("model_rdata", csr_rdata, rd);
    endtask

    task automatic advance();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic cyc(bit v, logic [11:0] a, csr_write_func f, logic [31:0] w, priv_mode_t p,
                       bit r, logic [3:0] h, bit t);
        set_in(v, a, f, w, p, r, h, t);
        settle();
        advance();
    endtask

    // Expects to be called at a negedge; leaves reset released at a negedge.
    task automatic apply_rst();
        reset_n = 1'b0;
        set_in(1'b1, 12'hB00, CsrRw, 32'hDEAD_BEEF, PrivM, 1'b1, 4'hF, 1'b1);
        #1;
        check("rst_rdata", csr_rdata, 32'h0);
        check("rst_illegal", {31'b0, csr_illegal}, 32'h0);
        csr_addr = 12'h7FF;
        #1;
        check("rst_illegal_badaddr", {31'b0, csr_illegal}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        set_in(1'b0, 12'h0, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned sum;
        bit          r;
        logic [11:0] addrs [23];
        logic [11:0] a;
        logic [31:0] w;
        priv_mode_t  p;

        vecs[0]  = '{1'b1, PrivM, 12'hB00, CsrNone, 32'h0,   1'b0, 32'h1111_1111};
        vecs[1]  = '{1'b1, PrivM, 12'hB80, CsrNone, 32'h0,   1'b0, 32'h0000_0022};
        vecs[2]  = '{1'b1, PrivM, 12'hB02, CsrNone, 32'h0,   1'b0, 32'h0000_0033};
        vecs[3]  = '{1'b1, PrivM, 12'hB03, CsrNone, 32'h0,   1'b0, 32'h0000_0044};
        vecs[4]  = '{1'b1, PrivM, 12'hB1F, CsrNone, 32'h0,   1'b0, 32'h0};
        vecs[5]  = '{1'b1, PrivM, 12'hB01, CsrNone, 32'h0,   1'b1, 32'h0};
        vecs[6]  = '{1'b1, PrivM, 12'h320, CsrNone, 32'h0,   1'b0, 32'h0000_007D};
        vecs[7]  = '{1'b1, PrivM, 12'h306, CsrNone, 32'h0,   1'b0, 32'h0000_0004};
        vecs[8]  = '{1'b1, PrivU, 12'hC02, CsrNone, 32'h0,   1'b0, 32'h0000_0033};
        vecs[9]  = '{1'b1, PrivU, 12'hC00, CsrNone, 32'h0,   1'b1, 32'h0};
        vecs[10] = '{1'b1, PrivU, 12'hB00, CsrNone, 32'h0,   1'b1, 32'h0};
        vecs[11] = '{1'b1, PrivM, 12'hC00, CsrRw,   32'h5,   1'b1, 32'h0};
        vecs[12] = '{1'b1, PrivM, 12'hC01, CsrNone, 32'h0,   1'b0, 32'h0};
        vecs[13] = '{1'b1, PrivS, 12'h320, CsrNone, 32'h0,   1'b1, 32'h0};
        vecs[14] = '{1'b1, PrivM, 12'h123, CsrNone, 32'h0,   1'b1, 32'h0};
        vecs[15] = '{1'b1, PrivM, 12'hCA0, CsrNone, 32'h0,   1'b1, 32'h0};
        vecs[16] = '{1'b1, PrivM, 12'hB9F, CsrNone, 32'h0,   1'b0, 32'h0};
        vecs[17] = '{1'b1, PrivU, 12'hC82, CsrNone, 32'h0,   1'b0, 32'h0};
        vecs[18] = '{1'b1, PrivM, 12'hC01, CsrRs,   32'h1,   1'b1, 32'h0};
        vecs[19] = '{1'b1, PrivM, 12'hC02, CsrRw,   32'hFF,  1'b1, 32'h0};
        vecs[20] = '{1'b0, PrivM, 12'hB00, CsrNone, 32'h0,   1'b0, 32'h0};
        vecs[21] = '{1'b1, PrivM, 12'hB02, CsrNone, 32'h0,   1'b0, 32'h0000_0033};

        addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB06,
                  12'hB86, 12'hB07, 12'hB1F, 12'hB01, 12'hC00, 12'hC01, 12'hC02, 12'hC03,
                  12'hC81, 12'hC86, 12'hC1F, 12'h320, 12'h306, 12'h123, 12'hB20};

        @(negedge clock);

        // Free-running count after reset.
        apply_rst();
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            r = 1'($urandom_range(0, 1));
            sum += r;
            cyc(1'b0, 12'h0, CsrNone, 32'h0, PrivM, r, 4'h0, 1'b0);
        end
        set_in(1'b1, 12'hB00, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("mcycle_after_10", csr_rdata, 32'd10);
        advance();
        set_in(1'b1, 12'hB02, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("minstret_sum", csr_rdata, sum);
        advance();

        // Carry from low into high half.
        cyc(1'b1, 12'hB00, CsrRw, 32'hFFFF_FFFF, PrivM, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 12'hB80, CsrRw, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        set_in(1'b1, 12'hB00, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("mcycle_lo_full", csr_rdata, 32'hFFFF_FFFF);
        advance();
        set_in(1'b1, 12'hB80, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("mcycle_hi_carry", csr_rdata, 32'h1);
        advance();

        // User access gated by mcounteren.
        apply_rst();
        set_in(1'b1, 12'hC00, CsrNone, 32'h0, PrivU, 1'b0, 4'h0, 1'b0);
        settle();
        check("user_cycle_illegal", {31'b0, csr_illegal}, 32'h1);
        check("user_cycle_rdata0", csr_rdata, 32'h0);
        advance();
        cyc(1'b1, 12'h306, CsrRs, 32'h1, PrivM, 1'b0, 4'h0, 1'b0);
        set_in(1'b1, 12'hC00, CsrNone, 32'h0, PrivU, 1'b0, 4'h0, 1'b0);
        settle();
        check("user_cycle_legal", {31'b0, csr_illegal}, 32'h0);
        check("user_cycle_value", csr_rdata, 32'd2);
        advance();

        // Inhibit freezes counters from the following cycle; bit 1 is hardwired.
        apply_rst();
        cyc(1'b1, 12'h320, CsrRs, 32'h5, PrivM, 1'b1, 4'h0, 1'b0);
        cyc(1'b0, 12'h0, CsrNone, 32'h0, PrivM, 1'b1, 4'h0, 1'b0);
        cyc(1'b0, 12'h0, CsrNone, 32'h0, PrivM, 1'b1, 4'h0, 1'b0);
        set_in(1'b1, 12'hB00, CsrNone, 32'h0, PrivM, 1'b1, 4'h0, 1'b0);
        settle();
        check("mcycle_frozen", csr_rdata, 32'h1);
        advance();
        set_in(1'b1, 12'hB02, CsrNone, 32'h0, PrivM, 1'b1, 4'h0, 1'b0);
        settle();
        check("minstret_frozen", csr_rdata, 32'h1);
        advance();
        set_in(1'b1, 12'h320, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("inhibit_readback", csr_rdata, 32'h5);
        advance();
        cyc(1'b1, 12'h320, CsrRw, 32'h2, PrivM, 1'b0, 4'h0, 1'b0);
        set_in(1'b1, 12'h320, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("inhibit_bit1_zero", csr_rdata, 32'h0);
        advance();
        set_in(1'b1, 12'hB00, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("mcycle_resumed", csr_rdata, 32'h2);
        advance();

        // Table of single-cycle accesses against a frozen, known state.
        apply_rst();
        cyc(1'b1, 12'h320, CsrRw, 32'hFFFF_FFFF, PrivM, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 12'hB00, CsrRw, 32'h1111_1111, PrivM, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 12'hB80, CsrRw, 32'h0000_0022, PrivM, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 12'hB02, CsrRw, 32'h0000_0033, PrivM, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 12'hB03, CsrRw, 32'h0000_0044, PrivM, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 12'h306, CsrRw, 32'h0000_0004, PrivM, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 22; i++) begin
            set_in(vecs[i].v, vecs[i].a, vecs[i].f, vecs[i].w, vecs[i].p, 1'b0, 4'h0, 1'b0);
            #1;
            check($sformatf("tbl%0d_illegal", i), {31'b0, csr_illegal}, {31'b0, vecs[i].ill});
            check($sformatf("tbl%0d_rdata", i), csr_rdata, vecs[i].rd);
            advance();
        end

        // Write colliding with an event, then a reset mid-access.
        apply_rst();
        cyc(1'b1, 12'hB03, CsrRw, 32'h1234, PrivM, 1'b0, 4'h1, 1'b0);
        set_in(1'b1, 12'hB03, CsrNone, 32'h0, PrivM, 1'b0, 4'h1, 1'b0);
        settle();
        check("hpm3_write_wins", csr_rdata, 32'h1234);
        advance();
        for (int i = 0; i < 4; i++) cyc(1'b0, 12'h0, CsrNone, 32'h0, PrivM, 1'b1, 4'hF, 1'b1);
        set_in(1'b1, 12'hB00, CsrRw, 32'hDEAD_BEEF, PrivM, 1'b1, 4'hF, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rdata", csr_rdata, 32'h0);
        check("midrst_illegal", {31'b0, csr_illegal}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        set_in(1'b0, 12'h0, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        reset_n = 1'b1;
        model_reset();
        set_in(1'b1, 12'hB00, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("midrst_mcycle0", csr_rdata, 32'h0);
        advance();
        set_in(1'b1, 12'hB03, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("midrst_hpm3_0", csr_rdata, 32'h0);
        advance();
        set_in(1'b1, 12'hB00, CsrNone, 32'h0, PrivM, 1'b0, 4'h0, 1'b0);
        settle();
        check("midrst_mcycle_resume", csr_rdata, 32'h2);
        advance();

        // Randomised traffic against the reference model.
        apply_rst();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) a = 12'($urandom);
            else a = addrs[$urandom_range(0, 22)];
            case ($urandom_range(0, 7))
                0, 1:    w = 32'hFFFF_FFFF;
                2:       w = 32'h0;
                3:       w = 32'($urandom_range(0, 7));
                default: w = $urandom;
            endcase
            if ($urandom_range(0, 9) < 7) p = PrivM;
            else p = ($urandom_range(0, 1) == 1) ? PrivU : PrivS;
            cyc(1'($urandom_range(0, 3) != 0), a, csr_write_func'(2'($urandom_range(0, 3))), w, p,
                1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_counters.md
CSR_COUNTERS -- requirements
Module: csr_counters

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, meaning the number of implemented mhpmcounter3.. counters (0..29).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 64, meaning the physical bit width of every counter (33..64).
REQ-003 SHALL have parameter RETIRE_MAX, default 1, meaning the maximum number of instructions retired per cycle.
REQ-004 SHALL have port clock  in  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port priv_mode  in  priv_mode_t  current privilege level.
REQ-007 SHALL have port csr_valid  in  1  CSR access request this cycle.
REQ-008 SHALL have port csr_addr  in  12  CSR address (csr_addr_t layout).
REQ-009 SHALL have port csr_func  in  csr_write_func  write function: NONE, RW, RS or RC.
REQ-010 SHALL have port csr_wdata  in  32  operand, already selected from rs1 or zero-extended imm.
REQ-011 SHALL have port csr_rdata  out  32  pre-write CSR value, combinational.
REQ-012 SHALL have port csr_illegal  out  1  access is illegal, combinational.
REQ-013 SHALL have port retire_count  in  $clog2(RETIRE_MAX+1)  instructions retired this cycle.
REQ-014 SHALL have port hpm_event  in  max(NUM_HPM,1)  per-counter event pulses; bit i drives mhpmcounter(3+i).
REQ-015 SHALL have port time_tick  in  1  timebase increment strobe.

Function
REQ-016 SHALL implement the counters mcycle, minstret, time and mhpmcounter3..(2+NUM_HPM), plus the 32-bit registers mcountinhibit and mcounteren.
REQ-017 SHALL map the counters to these addresses: mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, mhpmcounterN/h 0xB00+N/0xB80+N, user aliases 0xC00-0xC1F and 0xC80-0xC9F, mcountinhibit 0x320, mcounteren 0x306.
REQ-018 SHALL return counter bits [31:0] on a low-half read and bits [63:32] on a high-half read, with bits at or above COUNTER_WIDTH reading as zero.
REQ-019 SHALL treat mhpmcounter indices at or above 3+NUM_HPM as legal, reading zero, with writes ignored.
REQ-020 SHALL compute new = wdata for RW, old|wdata for RS and old&~wdata for RC, and SHALL commit it at the next rising edge when csr_valid=1 and csr_illegal=0.
REQ-021 SHALL perform no write when csr_func=NONE.
REQ-022 SHALL assert csr_illegal when the address is outside the set in REQ-017.
REQ-023 SHALL assert csr_illegal on a write (func!=NONE) to any 0xC-range alias.
REQ-024 SHALL assert csr_illegal on a 0xB or 0x3 range access while priv_mode is not machine.
REQ-025 SHALL assert csr_illegal on a non-machine 0xC-range access whose mcounteren bit (addr[4:0]) is clear.
REQ-026 SHALL drive csr_rdata to 0 when csr_illegal=1 or csr_valid=0.
REQ-027 SHALL each cycle, when the matching mcountinhibit bit is 0, increase mcycle by 1, minstret by retire_count, and mhpmcounterN by hpm_event[N-3].
REQ-028 SHALL increase time by 1 on time_tick, unaffected by inhibit, and SHALL keep time read-only.
REQ-029 SHALL wrap each counter from 2^COUNTER_WIDTH-1 to 0, carrying across the half boundary in the same cycle.
REQ-030 SHALL, when a write and an increment hit the same counter in one cycle, store the written value in the written half, drop that cycle's increment, and keep the other half unchanged.
REQ-031 SHALL hardwire mcountinhibit bit 1 to 0, together with bits above 2+NUM_HPM; mcounteren SHALL use the same writable-bit mask.
REQ-032 SHALL make a write to mcountinhibit take effect on increments from the following cycle.

Reset
REQ-033 SHALL, while reset_n=0, asynchronously clear all counters, mcountinhibit and mcounteren to 0.
REQ-034 SHALL, while reset_n=0, hold csr_rdata=0 and csr_illegal=0 regardless of other inputs.
REQ-035 SHALL, when reset asserts mid-access, discard the pending write, with counting resuming on the first edge after deassertion.

Structure
REQ-036 SHALL place the CSR address constants, writable-mask function and csr_write_func in csr_pkg.
REQ-037 SHALL contain one sub-module csr_counter (parametrised width, increment-by-N, half-write port), instantiated per counter.

Verification
REQ-038 SHALL cover: reset then 10 cycles uninhibited -> mcycle read at 0xB00 returns 10, minstret returns count of retire_count sum.
REQ-039 SHALL cover: RW 0xFFFFFFFF to 0xB00 then 0x0 to 0xB80, next cycle -> 0xB80 reads 1 after one increment (carry).
REQ-040 SHALL cover: user-mode read 0xC00 with mcounteren=0 -> csr_illegal=1, rdata=0; after machine RS 0x1 to 0x306 -> legal, returns mcycle.
REQ-041 SHALL cover: RS 0x5 to 0x320 -> mcycle and minstret frozen from the next cycle; 0x320 reads 0x5; bit1 write reads back 0.
REQ-042 SHALL cover: write 0xC02 or 0xC01 in machine mode -> csr_illegal=1, no state change; read 0xB1F with NUM_HPM=4 -> 0, legal.
REQ-043 SHALL cover: RW 0x1234 to 0xB03 coincident with hpm_event[0]=1 -> reads 0x1234 next cycle; reset_n pulse mid-stream -> all counters 0.
